// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-byte ALU sequencer.
//   state_t     : sequencer FSM states (IDLE, EXEC, DONE)
//   OP_*        : 3-bit ALU operation codes
//   promote_op  : maps the first-byte op to its carry-chaining form
//   is_arith    : true for add/adc/sub/sbc (op[2] == 0)
package alu_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    EXEC = S_EXEC,
    DONE = S_DONE
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_ANDN = 3'b111;

  // Upper bytes of add/sub must consume the carry/borrow of the byte below.
  function automatic logic [2:0] promote_op(input logic [2:0] op);
    case (op)
      OP_ADD:  return OP_ADC;
      OP_SUB:  return OP_SBC;
      default: return op;
    endcase
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-byte operation sequencer in front of an external 8-bit ALU.
// Accepts BYTES-wide requests (reqValid/reqReady), runs them LSB first one
// byte per cycle through the alu* ports with carry/borrow chaining, returns
// the full-width result (rspValid/rspReady) and keeps the C/Z flags.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqValid/reqReady/reqOp/reqA/B  request handshake, op code, operands
//   aluA/aluB/aluCarryIn/aluOp      drive to the ALU
//   aluResult/aluCarryOut/aluZero   combinational ALU response
//   rspValid/rspReady/rspResult     response handshake and full result
//   rspCarry/rspZero                final carry/borrow, full-word zero
//   flagC/flagZ, clrFlags           architectural flags, synchronous clear
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned BYTES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reqValid,
  output logic               reqReady,
  input  logic [2:0]         reqOp,
  input  logic [8*BYTES-1:0] reqA,
  input  logic [8*BYTES-1:0] reqB,
  output logic [7:0]         aluA,
  output logic [7:0]         aluB,
  output logic               aluCarryIn,
  output logic [2:0]         aluOp,
  input  logic [7:0]         aluResult,
  input  logic               aluCarryOut,
  input  logic               aluZero,
  output logic               rspValid,
  input  logic               rspReady,
  output logic [8*BYTES-1:0] rspResult,
  output logic               rspCarry,
  output logic               rspZero,
  output logic               flagC,
  output logic               flagZ,
  input  logic               clrFlags
);

  localparam int unsigned W  = 8 * BYTES;
  localparam int unsigned IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW+2:0]   bit_lo;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic            carry_q;
  logic            zacc_q;
  logic            last_byte;
  logic            finish;

  assign bit_lo    = {idx, 3'b000};
  assign last_byte = (idx == IW'(BYTES - 1));
  assign finish    = (state == EXEC) && last_byte;

  assign reqReady  = (state == IDLE);
  assign rspValid  = (state == DONE);
  assign rspResult = result_q;
  assign rspCarry  = carry_q;
  assign rspZero   = zacc_q;

  always_comb begin
    aluA       = '0;
    aluB       = '0;
    aluOp      = OP_ADD;
    aluCarryIn = 1'b0;
    if (state == EXEC) begin
      aluA       = a_q[bit_lo +: 8];
      aluB       = b_q[bit_lo +: 8];
      aluOp      = (idx == '0) ? op_q : promote_op(op_q);
      aluCarryIn = (idx == '0) ? flagC : carry_q;
    end
  end

  // carry_q is preloaded with flagC so logical ops report the acceptance-time
  // carry; only arithmetic bytes overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            op_q     <= reqOp;
            a_q      <= reqA;
            b_q      <= reqB;
            idx      <= '0;
            result_q <= '0;
            zacc_q   <= 1'b1;
            carry_q  <= flagC;
            state    <= EXEC;
          end
        end
        EXEC: begin
          result_q[bit_lo +: 8] <= aluResult;
          zacc_q                <= zacc_q & aluZero;
          if (is_arith(op_q)) carry_q <= aluCarryOut;
          if (last_byte) state <= DONE;
          else           idx   <= idx + 1'b1;
        end
        DONE: begin
          if (rspReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The completion update has priority over clrFlags; for logical ops flagC
  // is not part of the update, so a coincident clear still applies to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flagC <= 1'b0;
      flagZ <= 1'b0;
    end else if (finish) begin
      flagZ <= zacc_q & aluZero;
      if (is_arith(op_q)) flagC <= aluCarryOut;
      else if (clrFlags)  flagC <= 1'b0;
    end else if (clrFlags) begin
      flagC <= 1'b0;
      flagZ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int unsigned BYTES = 2;
  localparam int unsigned W     = 8 * BYTES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         reqValid = 1'b0;
  logic         reqReady;
  logic [2:0]   reqOp = '0;
  logic [W-1:0] reqA = '0;
  logic [W-1:0] reqB = '0;
  logic [7:0]   aluA, aluB, aluResult;
  logic         aluCarryIn, aluCarryOut, aluZero;
  logic [2:0]   aluOp;
  logic         rspValid;
  logic         rspReady = 1'b0;
  logic [W-1:0] rspResult;
  logic         rspCarry, rspZero;
  logic         flagC, flagZ;
  logic         clrFlags = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference flag state
  logic fC = 1'b0;
  logic fZ = 1'b0;

  alu_sequencer #(.BYTES(BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp), .reqA(reqA), .reqB(reqB),
    .aluA(aluA), .aluB(aluB), .aluCarryIn(aluCarryIn), .aluOp(aluOp),
    .aluResult(aluResult), .aluCarryOut(aluCarryOut), .aluZero(aluZero),
    .rspValid(rspValid), .rspReady(rspReady), .rspResult(rspResult),
    .rspCarry(rspCarry), .rspZero(rspZero),
    .flagC(flagC), .flagZ(flagZ), .clrFlags(clrFlags)
  );

  always #5 clk = ~clk;

  // Neighbouring 8-bit ALU; logical ops return a junk carry of 1.
  logic [8:0] alu_t;
  always_comb begin
    case (aluOp)
      3'b000:  alu_t = {1'b0, aluA} + {1'b0, aluB};
      3'b001:  alu_t = {1'b0, aluA} + {1'b0, aluB} + {8'b0, aluCarryIn};
      3'b010:  alu_t = {1'b0, aluA} - {1'b0, aluB};
      3'b011:  alu_t = {1'b0, aluA} - {1'b0, aluB} - {8'b0, aluCarryIn};
      3'b100:  alu_t = {1'b1, aluA & aluB};
      3'b101:  alu_t = {1'b1, aluA | aluB};
      3'b110:  alu_t = {1'b1, aluA ^ aluB};
      default: alu_t = {1'b1, aluA & ~aluB};
    endcase
  end
  assign aluResult   = alu_t[7:0];
  assign aluCarryOut = alu_t[8];
  assign aluZero     = (alu_t[7:0] == 8'h00);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Whole-word reference: {carry, result}
  function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, b,
                                        input logic cin);
    logic [W:0] ea, eb, ec;
    ea = {1'b0, a};
    eb = {1'b0, b};
    ec = {{W{1'b0}}, cin};
    case (op)
      3'd0:    return ea + eb;
      3'd1:    return ea + eb + ec;
      3'd2:    return ea - eb;
      3'd3:    return ea - eb - ec;
      3'd4:    return {cin, a & b};
      3'd5:    return {cin, a | b};
      3'd6:    return {cin, a ^ b};
      default: return {cin, a & ~b};
    endcase
  endfunction

  task automatic expect_txn(input logic [2:0] op, input logic [W-1:0] a, b, input bit clr_last,
                            output logic [W-1:0] er, output logic ec, ez);
    logic [W:0] r;
    r  = ref_op(op, a, b, fC);
    er = r[W-1:0];
    ec = r[W];
    ez = (er == '0);
    fZ = ez;
    if (!op[2])        fC = ec;
    else if (clr_last) fC = 1'b0;
  endtask

  // Issues one request from IDLE and waits (bounded) for rspValid.
  task automatic run_req(input logic [2:0] op, input logic [W-1:0] a, b, input bit clr_last,
                         output logic [W-1:0] res, output logic c, z, output int lat,
                         output logic [2:0] op0, op1);
    reqOp = op; reqA = a; reqB = b; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    op0 = aluOp; op1 = aluOp; lat = 0;
    while (rspValid !== 1'b1 && lat < int'(BYTES) + 8) begin
      if (lat == 1) op1 = aluOp;
      if (clr_last && lat == int'(BYTES) - 1) clrFlags = 1'b1;
      @(posedge clk); #1;
      clrFlags = 1'b0;
      lat++;
    end
    res = rspResult; c = rspCarry; z = rspZero;
  endtask

  task automatic finish_rsp();
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL reset_reqReady got %b exp 1", reqReady); end
    checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL reset_rspValid got %b exp 0", rspValid); end
    checks++; if ({rspResult, rspCarry, rspZero} !== '0) begin errors++; $display("FAIL reset_rsp got %h/%b/%b exp 0", rspResult, rspCarry, rspZero); end
    checks++; if ({flagC, flagZ} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b exp 00", flagC, flagZ); end
    checks++; if ({aluA, aluB, aluOp, aluCarryIn} !== '0) begin errors++; $display("FAIL reset_alu_drive got %h %h %b %b exp 0", aluA, aluB, aluOp, aluCarryIn); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL post_reset_reqReady got %b exp 1", reqReady); end
    fC = 1'b0; fZ = 1'b0;
  endtask

  logic [2:0]   t_op [5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2};
  logic [W-1:0] t_a  [5] = '{16'h00FF, 16'hFFFF, 16'h0000, 16'h0100, 16'h0000};
  logic [W-1:0] t_b  [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0001};
  logic [W-1:0] t_r  [5] = '{16'h0100, 16'h0000, 16'h0001, 16'h00FF, 16'hFFFF};
  logic         t_c  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic         t_z  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic test_arith_directed();
    logic [W-1:0] res; logic c, z; int lat; logic [2:0] op0, op1, prom;
    for (int i = 0; i < 5; i++) begin
      run_req(t_op[i], t_a[i], t_b[i], 1'b0, res, c, z, lat, op0, op1);
      prom = t_op[i][2] ? t_op[i] : {t_op[i][2:1], 1'b1};
      checks++; if (lat != int'(BYTES)) begin errors++; $display("FAIL arith%0d_latency got %0d exp %0d", i, lat, BYTES); end
      checks++; if (res !== t_r[i]) begin errors++; $display("FAIL arith%0d_result got %h exp %h", i, res, t_r[i]); end
      checks++; if (c !== t_c[i] || z !== t_z[i]) begin errors++; $display("FAIL arith%0d_cz got %b%b exp %b%b", i, c, z, t_c[i], t_z[i]); end
      checks++; if (flagC !== t_c[i] || flagZ !== t_z[i]) begin errors++; $display("FAIL arith%0d_flags got %b%b exp %b%b", i, flagC, flagZ, t_c[i], t_z[i]); end
      checks++; if (op0 !== t_op[i] || op1 !== prom) begin errors++; $display("FAIL arith%0d_aluOp got %b,%b exp %b,%b", i, op0, op1, t_op[i], prom); end
      checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL arith%0d_reqReady_done got %b exp 0", i, reqReady); end
      finish_rsp();
      fC = t_c[i]; fZ = t_z[i];
    end
  endtask

  task automatic test_logic_clr();
    logic [W-1:0] res; logic c, z; int lat; logic [2:0] op0, op1;
    // flagC is 1 from the preceding borrow
    run_req(3'd4, 16'hF0F0, 16'h0F0F, 1'b0, res, c, z, lat, op0, op1);
    checks++; if (res !== 16'h0000 || z !== 1'b1 || c !== 1'b1) begin errors++; $display("FAIL logic_and got %h c%b z%b exp 0000 c1 z1", res, c, z); end
    checks++; if (flagC !== 1'b1 || flagZ !== 1'b1) begin errors++; $display("FAIL logic_flags got %b%b exp 11", flagC, flagZ); end
    finish_rsp();
    clrFlags = 1'b1;
    @(posedge clk); #1;
    clrFlags = 1'b0;
    checks++; if (flagC !== 1'b0 || flagZ !== 1'b0) begin errors++; $display("FAIL clr_flags got %b%b exp 00", flagC, flagZ); end
    fC = 1'b0; fZ = 1'b0;
  endtask

  task automatic test_clr_collide();
    logic [W-1:0] res; logic c, z; int lat; logic [2:0] op0, op1;
    run_req(3'd0, 16'hFFFF, 16'h0001, 1'b1, res, c, z, lat, op0, op1);
    checks++; if (flagC !== 1'b1 || flagZ !== 1'b1) begin errors++; $display("FAIL clr_collide_flags got %b%b exp 11", flagC, flagZ); end
    finish_rsp();
    fC = 1'b1; fZ = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res, er; logic c, z, ec, ez; int lat; logic [2:0] op0, op1;
    logic [W-1:0] a, b;
    bit bad;
    a = W'($urandom); b = W'($urandom);
    expect_txn(3'd3, a, b, 1'b0, er, ec, ez);
    run_req(3'd3, a, b, 1'b0, res, c, z, lat, op0, op1);
    checks++; if (res !== er || c !== ec || z !== ez) begin errors++; $display("FAIL bp_result got %h %b%b exp %h %b%b", res, c, z, er, ec, ez); end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rspValid !== 1'b1 || reqReady !== 1'b0 || rspResult !== res || rspCarry !== c || rspZero !== z) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL bp_stable got v%b r%b %h exp v1 r0 %h", rspValid, reqReady, rspResult, res); end
    finish_rsp();
    checks++; if (reqReady !== 1'b1 || rspValid !== 1'b0) begin errors++; $display("FAIL bp_release got r%b v%b exp r1 v0", reqReady, rspValid); end
  endtask

  task automatic test_reset_mid_exec();
    logic [W-1:0] res, er; logic c, z, ec, ez; int lat; logic [2:0] op0, op1;
    reqOp = 3'd0; reqA = 16'hFFFF; reqB = 16'hFFFF; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (reqReady !== 1'b1 || rspValid !== 1'b0) begin errors++; $display("FAIL rst_exec_hs got r%b v%b exp r1 v0", reqReady, rspValid); end
    checks++; if ({rspResult, rspCarry, rspZero, flagC, flagZ} !== '0) begin errors++; $display("FAIL rst_exec_state got %h %b%b %b%b exp 0", rspResult, rspCarry, rspZero, flagC, flagZ); end
    checks++; if ({aluA, aluB, aluOp, aluCarryIn} !== '0) begin errors++; $display("FAIL rst_exec_alu got %h %h exp 0", aluA, aluB); end
    #2 rst_n = 1'b1;
    fC = 1'b0; fZ = 1'b0;
    @(posedge clk); #1;
    expect_txn(3'd1, 16'h1234, 16'h0FCD, 1'b0, er, ec, ez);
    run_req(3'd1, 16'h1234, 16'h0FCD, 1'b0, res, c, z, lat, op0, op1);
    checks++; if (res !== er || res !== 16'h2201 || c !== ec || z !== ez) begin errors++; $display("FAIL rst_exec_next got %h %b%b exp %h %b%b", res, c, z, er, ec, ez); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res, er; logic c, z, ec, ez; int lat; logic [2:0] op0, op1;
    for (int i = 0; i < 3; i++) begin
      expect_txn(3'(i + 4), 16'h5AA5, 16'h0FF0, 1'b0, er, ec, ez);
      run_req(3'(i + 4), 16'h5AA5, 16'h0FF0, 1'b0, res, c, z, lat, op0, op1);
      checks++; if (res !== er || lat != int'(BYTES)) begin errors++; $display("FAIL b2b%0d got %h lat %0d exp %h lat %0d", i, res, lat, er, BYTES); end
      finish_rsp();
      checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready got %b exp 1", i, reqReady); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] res, er, a, b; logic c, z, ec, ez; int lat; logic [2:0] op, op0, op1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        clrFlags = 1'b1;
        @(posedge clk); #1;
        clrFlags = 1'b0;
        fC = 1'b0; fZ = 1'b0;
      end
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? a : W'($urandom);
      expect_txn(op, a, b, 1'b0, er, ec, ez);
      run_req(op, a, b, 1'b0, res, c, z, lat, op0, op1);
      checks++;
      if (res !== er || c !== ec || z !== ez || flagC !== fC || flagZ !== fZ || lat != int'(BYTES)) begin
        errors++;
        $display("FAIL rand%0d op%0d %h,%h got %h c%b z%b f%b%b lat%0d exp %h c%b z%b f%b%b",
                 i, op, a, b, res, c, z, flagC, flagZ, lat, er, ec, ez, fC, fZ);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      finish_rsp();
    end
  endtask

  initial begin
    test_reset();
    test_arith_directed();
    test_logic_clr();
    test_clr_collide();
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
